muland_result_collector: RTL and testbench
==========================================

// Module: muland_result_collector
// PURPOSE
//   Downstream stage of the 2-stage (a*b)&c DSP pipeline. That pipeline cannot stall and carries no valid bit;
//   this block tracks issue-valid alongside it, captures p when its data emerges, and buffers results in a FIFO
//   behind a ready/valid output. Credit-based in_ready guarantees no in-flight result is ever lost.
// PARAMETERS
//   WIDTH       16  result width (matches p)
//   PIPE_DEPTH   2  latency of upstream muland pipeline, cycles from operand issue to p
//   DEPTH        8  FIFO entries; power of two, >= PIPE_DEPTH+1
// PORTS
//   clk        in   1                      single clock, rising edge
//   rst_n      in   1                      asynchronous, active-low reset
//   in_valid   in   1                      operands a/b/c driven into upstream pipeline this cycle
//   in_ready   out  1                      issue permitted this cycle (credit available)
//   p          in   WIDTH                  upstream pipeline output
//   out_valid  out  1                      out_data holds a valid result
//   out_ready  in   1                      consumer accepts out_data
//   out_data   out  WIDTH                  FIFO head
//   level      out  $clog2(DEPTH)+1        FIFO occupancy
//   overflow   out  1                      sticky: issue attempted without credit
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   Reset: valid pipe all 0, FIFO empty, pointers 0, out_valid=0, out_data=0, level=0, overflow=0, in_ready=1.
//   Issue: accepted when in_valid && in_ready; shifts 1 into PIPE_DEPTH-bit valid pipe, else 0.
//   Capture: when valid pipe tail == 1, p is written to FIFO at that edge. p is ignored otherwise
//     (upstream regs are unreset; X/garbage on p must never enter FIFO).
//   Latency: issue at edge t -> p valid in cycle t+PIPE_DEPTH -> out_valid earliest cycle t+PIPE_DEPTH+1.
//   Credit: in_ready = (level + popcount(valid pipe)) < DEPTH; combinational from registers only,
//     never from out_ready (no pop-through credit). Hence a capture never finds FIFO full.
//   Reject: in_valid && !in_ready -> not entered into valid pipe, overflow<=1, held until reset.
//   Output: out_valid = (level != 0); out_data = mem[rd_ptr]; pop on out_valid && out_ready.
//     out_data/out_valid stable while out_valid && !out_ready.
//   Simultaneous push+pop: level unchanged, both pointers advance; allowed at level==DEPTH-... and at 1.
//   Push into empty FIFO with out_ready=1: out_valid rises next cycle (no fall-through).
//   Pointers: $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 silently.
//   Pop when empty: ignored (out_valid=0). 
//   Reset mid-operation: in-flight valid bits and FIFO contents discarded; upstream results emerging after
//     deassertion are ignored because valid pipe is 0.
// STRUCTURE
//   Shared package muland_pkg: MULAND_WIDTH=16, MULAND_PIPE_DEPTH=2, typedef logic [MULAND_WIDTH-1:0] muland_word_t.
//   Sub-module muland_result_fifo (mem, rd/wr pointers, level, out_valid) instantiated once;
//   valid pipe, credit logic and overflow flag stay in this top.
// TESTING (bench wraps collector with behavioural 2-cycle (a*b)&c model)
//   1 Single issue a=3,b=5,c=16'hFFFF at cycle 0, out_ready=1 -> out_valid cycle 3, out_data=16'h000F, level back 0.
//   2 Back-to-back issue of 8 ops (a=i+1,b=2,c=16'hFFFF), out_ready=0 -> in_ready falls after 8th issue,
//     level=8, overflow=0; then out_ready=1 -> results 2,4,..,16 in order, in_ready re-rises.
//   3 With in_ready=0 assert in_valid -> overflow=1 and stays 1; level/contents unchanged.
//   4 Streaming issue every cycle with out_ready=1 for 20 cycles (wrap both pointers twice) -> all 20
//     results in order, level never exceeds 1 after steady state, no gaps after first out_valid.
//   5 Truncation: a=16'hFFFF,b=16'hFFFF,c=16'h00FF -> out_data=16'h0001 (low 16 bits of product, then AND).
//   6 Drive rst_n low with 2 in flight and 3 buffered -> out_valid=0, level=0, overflow=0 asynchronously;
//     emerging p values after release never appear on out_data.

Source files
------------

// File: rtl/muland_pkg.sv
// Shared constants and types for the muland (a*b)&c pipeline and its result collector.
package muland_pkg;

  localparam int MULAND_WIDTH      = 16;
  localparam int MULAND_PIPE_DEPTH = 2;
  localparam int MULAND_DEPTH      = 8;

  typedef logic [MULAND_WIDTH-1:0] muland_word_t;

  function automatic int unsigned muland_popcount(input logic [31:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += 32'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/muland_result_fifo.sv
// Result buffer for the collector: registered-output FIFO with occupancy count,
// no fall-through, and a head that holds steady until popped.
module muland_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             popReady_i,
  output logic             outValid_o,
  output logic [WIDTH-1:0] outData_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             pop;

  assign outValid_o = (level_q != '0);
  assign outData_o  = mem_q[rdPtr_q];
  assign level_o    = level_q;

  // Popping an empty FIFO is silently dropped; pointers wrap naturally at DEPTH.
  always_comb begin
    pop     = outValid_o && popReady_i;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push_i) wrPtr_d = wrPtr_q + PW'(1);
    if (pop)    rdPtr_d = rdPtr_q + PW'(1);
    unique case ({push_i, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
      if (push_i) mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/muland_result_collector.sv
// Tracks issue-valid alongside the unstallable muland pipeline, captures p when a
// valid result emerges, and throttles issue with credits so no result is ever dropped.
module muland_result_collector
  import muland_pkg::*;
#(
  parameter int WIDTH      = MULAND_WIDTH,
  parameter int PIPE_DEPTH = MULAND_PIPE_DEPTH,
  parameter int DEPTH      = MULAND_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         p,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  logic [PIPE_DEPTH-1:0] validPipe_q, validPipe_d;
  logic                  overflow_q, overflow_d;
  logic                  issue;
  logic                  capture;
  int unsigned           creditsUsed;

  // Credits count both buffered and in-flight results, and deliberately ignore
  // out_ready so a capture can never land on a full FIFO.
  always_comb begin
    creditsUsed = 32'(level) + muland_popcount(32'(validPipe_q));
    in_ready    = (creditsUsed < 32'(DEPTH));
    issue       = in_valid && in_ready;
    capture     = validPipe_q[PIPE_DEPTH-1];
    validPipe_d = (validPipe_q << 1) | PIPE_DEPTH'(issue);
    overflow_d  = overflow_q || (in_valid && !in_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validPipe_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      validPipe_q <= validPipe_d;
      overflow_q  <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  muland_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (capture),
    .pushData_i (p),
    .popReady_i (out_ready),
    .outValid_o (out_valid),
    .outData_o  (out_data),
    .level_o    (level)
  );

endmodule

// File: tb/tb_muland_result_collector.sv
// Bench for muland_result_collector: wraps it with a behavioural 2-cycle (a*b)&c
// pipeline and compares every cycle against a queue-based model of issued results.
module tb_muland_result_collector;
  import muland_pkg::*;

  localparam int DEPTH = 8;

  typedef struct {
    int           due;
    muland_word_t val;
  } flight_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  muland_word_t p;
  logic         out_valid;
  logic         out_ready;
  muland_word_t out_data;
  logic [3:0]   level;
  logic         overflow;

  muland_word_t a, b, c;
  muland_word_t s1Prod, s1C;

  muland_word_t expQ[$];
  flight_t      flightQ[$];
  bit           expOverflow;
  int           cyc;
  int           errors;
  int           checks;
  int           maxLevel;

  muland_result_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream pipeline: unreset, runs every cycle regardless of validity.
  always @(posedge clk) begin
    s1Prod <= a * b;
    s1C    <= c;
    p      <= s1Prod & s1C;
  end

  function automatic muland_word_t mulAnd(input muland_word_t x, input muland_word_t y,
                                          input muland_word_t z);
    logic [31:0] full;
    full = {16'h0, x} * {16'h0, y};
    return full[15:0] & z;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic checkModel();
    checkOutput("in_ready", {31'h0, in_ready},
                {31'h0, ((expQ.size() + flightQ.size()) < DEPTH)});
    checkOutput("out_valid", {31'h0, out_valid}, {31'h0, (expQ.size() != 0)});
    checkOutput("level", {28'h0, level}, 32'(expQ.size()));
    checkOutput("overflow", {31'h0, overflow}, {31'h0, expOverflow});
    if (expQ.size() != 0) checkOutput("out_data", {16'h0, out_data}, {16'h0, expQ[0]});
  endtask

  // Drives one cycle of inputs, clocks, advances the model and compares.
  task automatic applyStimulus(input bit iv, input muland_word_t ia, input muland_word_t ib,
                               input muland_word_t ic, input bit ordy);
    bit           popOk, issueOk;
    muland_word_t issueVal;
    flight_t      f;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    c         = ic;
    out_ready = ordy;
    popOk     = ordy && (expQ.size() != 0);
    issueOk   = iv && ((expQ.size() + flightQ.size()) < DEPTH);
    if (iv && !issueOk) expOverflow = 1'b1;
    issueVal  = mulAnd(ia, ib, ic);
    @(posedge clk);
    #1;
    cyc++;
    if (popOk) void'(expQ.pop_front());
    while (flightQ.size() != 0 && flightQ[0].due == cyc) begin
      f = flightQ.pop_front();
      expQ.push_back(f.val);
    end
    if (issueOk) flightQ.push_back('{cyc + 2, issueVal});
    checkModel();
  endtask

  task automatic idle(input bit ordy, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), ordy);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors      = 0;
    checks      = 0;
    cyc         = 0;
    expOverflow = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    c           = '0;

    #12;
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_out_data", {16'h0, out_data}, 32'h0);
    checkOutput("rst_level", {28'h0, level}, 32'h0);
    checkOutput("rst_overflow", {31'h0, overflow}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single issue, result visible three cycles later
    applyStimulus(1'b1, 16'd3, 16'd5, 16'hFFFF, 1'b1);
    applyStimulus(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    checkOutput("t1_not_early", {31'h0, out_valid}, 32'h0);
    applyStimulus(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    checkOutput("t1_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("t1_out_data", {16'h0, out_data}, 32'h000F);
    applyStimulus(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
    checkOutput("t1_level_zero", {28'h0, level}, 32'h0);

    // 2: fill all credits with the consumer stalled
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'(i + 1), 16'd2, 16'hFFFF, 1'b0);
    end
    checkOutput("t2_credit_exhausted", {31'h0, in_ready}, 32'h0);
    idle(1'b0, 2);
    checkOutput("t2_level_full", {28'h0, level}, 32'h8);
    checkOutput("t2_no_overflow", {31'h0, overflow}, 32'h0);

    // 3: issue without credit is rejected and sticks
    applyStimulus(1'b1, 16'd9, 16'd9, 16'hFFFF, 1'b0);
    checkOutput("t3_overflow_set", {31'h0, overflow}, 32'h1);
    checkOutput("t3_level_kept", {28'h0, level}, 32'h8);
    checkOutput("t3_head_kept", {16'h0, out_data}, 32'h2);
    idle(1'b0, 1);
    checkOutput("t3_overflow_sticky", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t2_drain_order", {16'h0, out_data}, 32'(2 * (i + 1)));
      idle(1'b1, 1);
    end
    checkOutput("t2_in_ready_back", {31'h0, in_ready}, 32'h1);

    // 4: streaming, one issue per cycle, pointers wrap twice
    maxLevel = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
      if (i >= 2) begin
        checkOutput("t4_no_gap", {31'h0, out_valid}, 32'h1);
        if (int'(level) > maxLevel) maxLevel = int'(level);
      end
    end
    checkOutput("t4_max_level", 32'(maxLevel), 32'h1);
    idle(1'b1, 4);

    // 5: product truncated to 16 bits before the AND
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 16'h00FF, 1'b0);
    idle(1'b0, 2);
    checkOutput("t5_truncation", {16'h0, out_data}, 32'h0001);
    idle(1'b1, 2);

    // Random traffic: slow consumer first, then a fast one
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 16'($urandom),
                    (i < 150) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0));
    end
    idle(1'b1, 12);

    // 6: asynchronous reset with 3 buffered and 2 in flight
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'(i + 7), 16'd3, 16'hFFFF, 1'b0);
    end
    checkOutput("t6_buffered", {28'h0, level}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("t6_async_level", {28'h0, level}, 32'h0);
    checkOutput("t6_async_overflow", {31'h0, overflow}, 32'h0);
    checkOutput("t6_async_out_data", {16'h0, out_data}, 32'h0);
    expQ.delete();
    flightQ.delete();
    expOverflow = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 1);
      checkOutput("t6_ghost_data", {16'h0, out_data}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
